// File: rtl/lcd_i2c_pkg.sv
// Shared definitions for the LCD-to-PCF8574 packer: backpack bit map, sequencer states,
// HD44780 commands that need the long execution delay.
package lcd_i2c_pkg;

   localparam int BIT_BL = 3;
   localparam int BIT_EN = 2;
   localparam int BIT_RW = 1;
   localparam int BIT_RS = 0;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   typedef enum logic [2:0] {
      IDLE,
      HI_EN,
      HI_DIS,
      LO_EN,
      LO_DIS,
      WAIT
   } state_t;

   // Places one LCD nibble plus control lines into the backpack byte; RW is always write.
   function automatic logic [7:0] pack_byte(input logic [3:0] nib, input logic bl,
                                            input logic en, input logic rs);
      logic [7:0] b;
      b         = {nib, 4'b0000};
      b[BIT_BL] = bl;
      b[BIT_EN] = en;
      b[BIT_RW] = 1'b0;
      b[BIT_RS] = rs;
      return b;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter for the HD44780 execution delay; done is high while the count is zero.
module lcd_delay_timer #(
   parameter int W = 8
) (
   input  logic         ck,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (load)
         r_cnt <= load_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign done = (r_cnt == '0);

endmodule

// File: rtl/lcd_i2c_packer.sv
// Splits LCD command/data bytes into PCF8574 EN-strobed nibble writes, then idles for the LCD delay.
// Define BACKLIGHT_CTRL_EN to add the bl_on input (sampled per byte); otherwise BL = BL_DEFAULT.
module lcd_i2c_packer
   import lcd_i2c_pkg::*;
#(
   parameter int SHORT_WAIT = 2000,
   parameter int LONG_WAIT  = 80000,
   parameter bit BL_DEFAULT = 1'b1
) (
   input  logic       ck,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic       in_rs,
   input  logic       in_nib,
`ifdef BACKLIGHT_CTRL_EN
   input  logic       bl_on,
`endif
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       busy
);

   // Floored at one bit so a build with both waits at zero still elaborates.
   localparam int CW = $clog2(max_int(max_int(LONG_WAIT, SHORT_WAIT) + 1, 2));
   localparam logic [CW-1:0] SHORT_LOAD = (SHORT_WAIT > 0) ? CW'(SHORT_WAIT - 1) : '0;
   localparam logic [CW-1:0] LONG_LOAD  = (LONG_WAIT > 0)  ? CW'(LONG_WAIT - 1)  : '0;

   state_t     r_state;
   logic [7:0] r_byte;
   logic       r_rs;
   logic       r_nib;
   logic       r_long;
   logic       r_out_valid;
   logic [7:0] r_out_data;

   logic          w_fire;
   logic          w_last;
   logic          w_wait_zero;
   logic          w_timer_load;
   logic          w_timer_done;
   logic [CW-1:0] w_load_val;
   logic          w_long_now;
   logic          w_bl_now;
   logic          w_bl;
   state_t        w_after;

`ifdef BACKLIGHT_CTRL_EN
   logic r_bl;
   assign w_bl_now = bl_on;
   assign w_bl     = r_bl;
`else
   assign w_bl_now = BL_DEFAULT;
   assign w_bl     = BL_DEFAULT;
`endif

   assign w_fire       = r_out_valid & out_ready;
   assign w_long_now   = ~in_rs & ((in_byte == CMD_CLEAR) | (in_byte == CMD_HOME));
   assign w_last       = (r_state == LO_DIS) | ((r_state == HI_DIS) & r_nib);
   assign w_wait_zero  = r_long ? (LONG_WAIT == 0) : (SHORT_WAIT == 0);
   assign w_load_val   = r_long ? LONG_LOAD : SHORT_LOAD;
   assign w_timer_load = w_fire & w_last & ~w_wait_zero;
   assign w_after      = w_wait_zero ? IDLE : WAIT;

   lcd_delay_timer #(.W(CW)) u_timer (
      .ck       (ck),
      .reset    (reset),
      .load     (w_timer_load),
      .load_val (w_load_val),
      .done     (w_timer_done)
   );

   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_byte      <= '0;
         r_rs        <= 1'b0;
         r_nib       <= 1'b0;
         r_long      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
`ifdef BACKLIGHT_CTRL_EN
         r_bl        <= BL_DEFAULT;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_byte      <= in_byte;
                  r_rs        <= in_rs;
                  r_nib       <= in_nib;
                  r_long      <= w_long_now;
`ifdef BACKLIGHT_CTRL_EN
                  r_bl        <= bl_on;
`endif
                  r_out_valid <= 1'b1;
                  r_out_data  <= pack_byte(in_byte[7:4], w_bl_now, 1'b1, in_rs);
                  r_state     <= HI_EN;
               end
            end
            HI_EN: begin
               if (w_fire) begin
                  r_out_data <= pack_byte(r_byte[7:4], w_bl, 1'b0, r_rs);
                  r_state    <= HI_DIS;
               end
            end
            HI_DIS: begin
               if (w_fire) begin
                  if (w_last) begin
                     r_out_valid <= 1'b0;
                     r_state     <= w_after;
                  end else begin
                     r_out_data <= pack_byte(r_byte[3:0], w_bl, 1'b1, r_rs);
                     r_state    <= LO_EN;
                  end
               end
            end
            LO_EN: begin
               if (w_fire) begin
                  r_out_data <= pack_byte(r_byte[3:0], w_bl, 1'b0, r_rs);
                  r_state    <= LO_DIS;
               end
            end
            LO_DIS: begin
               if (w_fire) begin
                  r_out_valid <= 1'b0;
                  r_state     <= w_after;
               end
            end
            WAIT: begin
               if (w_timer_done)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_lcd_i2c_packer.sv
// Self-checking bench for lcd_i2c_packer: directed cases, then random bytes with random backpressure.
module tb_lcd_i2c_packer;

   localparam int SW = 4;
   localparam int LW = 10;

   logic ck = 1'b0;
   logic reset = 1'b0;

   logic       a_in_valid, a_in_ready, a_in_rs, a_in_nib;
   logic       a_out_valid, a_out_ready, a_busy;
   logic [7:0] a_in_byte, a_out_data;

   logic       b_in_valid, b_in_ready, b_in_rs, b_in_nib;
   logic       b_out_valid, b_out_ready, b_busy;
   logic [7:0] b_in_byte, b_out_data;

`ifdef BACKLIGHT_CTRL_EN
   logic bl_on = 1'b1;
`endif

   int n_pass   = 0;
   int n_fail   = 0;
   int n_checks = 0;

   logic [7:0] exp_q[$];

   always #5 ck = ~ck;

   lcd_i2c_packer #(.SHORT_WAIT(SW), .LONG_WAIT(LW)) dut_a (
      .ck        (ck),
      .reset     (reset),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_byte   (a_in_byte),
      .in_rs     (a_in_rs),
      .in_nib    (a_in_nib),
`ifdef BACKLIGHT_CTRL_EN
      .bl_on     (bl_on),
`endif
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .busy      (a_busy)
   );

   lcd_i2c_packer #(.SHORT_WAIT(0), .LONG_WAIT(3)) dut_b (
      .ck        (ck),
      .reset     (reset),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_byte   (b_in_byte),
      .in_rs     (b_in_rs),
      .in_nib    (b_in_nib),
`ifdef BACKLIGHT_CTRL_EN
      .bl_on     (bl_on),
`endif
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .busy      (b_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: one strobed pair per nibble, upper first; bit weights follow the backpack map.
   function automatic void fill_exp(input logic [7:0] b, input logic rs, input logic nib,
                                    input logic bl);
      int hi, lo;
      hi = int'(b) / 16;
      lo = int'(b) % 16;
      exp_q = {};
      exp_q.push_back(8'(hi * 16 + int'(bl) * 8 + 4 + int'(rs)));
      exp_q.push_back(8'(hi * 16 + int'(bl) * 8 + int'(rs)));
      if (!nib) begin
         exp_q.push_back(8'(lo * 16 + int'(bl) * 8 + 4 + int'(rs)));
         exp_q.push_back(8'(lo * 16 + int'(bl) * 8 + int'(rs)));
      end
   endfunction

   function automatic int exp_wait(input logic [7:0] b, input logic rs, input int sw, input int lw);
      return (!rs && (b == 8'd1 || b == 8'd2)) ? lw : sw;
   endfunction

   function automatic logic pick_bl();
`ifdef BACKLIGHT_CTRL_EN
      return 1'($urandom_range(0, 1));
`else
      return 1'b1;
`endif
   endfunction

   // mode 0: ready always high; 1: random ready; 2: ready held low for 5 cycles of HI_EN.
   task automatic send_a(input logic [7:0] b, input logic rs, input logic nib, input logic bl,
                         input int mode, input string tag);
      int idx, cyc, stall, waited;
      logic r;
      fill_exp(b, rs, nib, bl);
      check({tag, "_in_ready_idle"}, a_in_ready, 1);
      a_in_valid = 1'b1;
      a_in_byte  = b;
      a_in_rs    = rs;
      a_in_nib   = nib;
`ifdef BACKLIGHT_CTRL_EN
      bl_on      = bl;
`endif
      a_out_ready = (mode == 0);
      @(negedge ck);
      a_in_valid = 1'b0;
      a_in_byte  = 8'($urandom);
      a_in_rs    = 1'($urandom);
      a_in_nib   = 1'($urandom);
`ifdef BACKLIGHT_CTRL_EN
      bl_on      = 1'($urandom);
`endif
      idx = 0; cyc = 0; stall = 0;
      while (idx < exp_q.size() && cyc < 200) begin
         check({tag, "_out_valid"}, a_out_valid, 1);
         check({tag, "_out_data"}, a_out_data, exp_q[idx]);
         check({tag, "_busy"}, a_busy, 1);
         check({tag, "_in_ready_busy"}, a_in_ready, 0);
         case (mode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: begin r = (idx > 0) || (stall >= 5); stall++; end
         endcase
         a_out_ready = r;
         if (r) idx++;
         cyc++;
         @(negedge ck);
      end
      check({tag, "_all_bytes_seen"}, idx, exp_q.size());
      if (mode == 0) check({tag, "_consecutive"}, cyc, exp_q.size());
      if (mode == 2) check({tag, "_stall_cycles"}, cyc, exp_q.size() + 5);
      waited = 0;
      while (!a_in_ready && waited < LW + 50) begin
         check({tag, "_wait_valid_low"}, a_out_valid, 0);
         check({tag, "_wait_busy"}, a_busy, 1);
         a_out_ready = 1'($urandom);
         waited++;
         @(negedge ck);
      end
      check({tag, "_wait_len"}, waited, exp_wait(b, rs, SW, LW));
      check({tag, "_idle_busy"}, a_busy, 0);
      a_out_ready = 1'b0;
   endtask

   initial begin
      int slots[$];
      logic [7:0] rb;
      logic rrs, rnib;
      a_in_valid = 0; a_in_byte = 0; a_in_rs = 0; a_in_nib = 0; a_out_ready = 0;
      b_in_valid = 0; b_in_byte = 0; b_in_rs = 0; b_in_nib = 0; b_out_ready = 0;
      repeat (3) @(negedge ck);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data", a_out_data, 8'h00);
      check("rst_busy", a_busy, 0);
      check("rst_in_ready", a_in_ready, 1);
      reset = 1'b1;
      @(negedge ck);

      send_a(8'h41, 1'b1, 1'b0, 1'b1, 0, "data41");
      send_a(8'h01, 1'b0, 1'b0, 1'b1, 0, "clear");
      send_a(8'h02, 1'b1, 1'b0, 1'b1, 0, "data02_short");
      send_a(8'h30, 1'b0, 1'b1, 1'b1, 0, "nibble30");
      send_a(8'h41, 1'b1, 1'b0, 1'b1, 2, "backpressure");
`ifdef BACKLIGHT_CTRL_EN
      send_a(8'h41, 1'b1, 1'b0, 1'b0, 0, "bl_off");
`endif

      // Reset asserted while the low-nibble EN byte is on the bus.
      a_in_valid = 1'b1; a_in_byte = 8'h41; a_in_rs = 1'b1; a_in_nib = 1'b0; a_out_ready = 1'b1;
`ifdef BACKLIGHT_CTRL_EN
      bl_on = 1'b1;
`endif
      @(negedge ck);
      a_in_valid = 1'b0;
      @(negedge ck);
      @(negedge ck);
      check("mid_lo_en_data", a_out_data, 8'h1D);
      reset = 1'b0;
      #1;
      check("abort_out_valid", a_out_valid, 0);
      check("abort_out_data", a_out_data, 8'h00);
      check("abort_busy", a_busy, 0);
      check("abort_in_ready", a_in_ready, 1);
      @(negedge ck);
      reset = 1'b1;
      a_out_ready = 1'b0;
      @(negedge ck);
      send_a(8'h52, 1'b1, 1'b0, 1'b1, 0, "after_abort");

      for (int t = 0; t < 30; t++) begin
         rb   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
         rrs  = 1'($urandom_range(0, 1));
         rnib = ($urandom_range(0, 3) == 0);
         send_a(rb, rrs, rnib, pick_bl(), 1, $sformatf("rnd%0d", t));
      end

      // Zero short wait, in_valid held high: two sequences one idle cycle apart.
`ifdef BACKLIGHT_CTRL_EN
      bl_on = 1'b1;
`endif
      slots = {};
      fill_exp(8'h41, 1'b1, 1'b0, 1'b1);
      foreach (exp_q[i]) slots.push_back(int'(exp_q[i]));
      slots.push_back(-1);
      fill_exp(8'h52, 1'b1, 1'b0, 1'b1);
      foreach (exp_q[i]) slots.push_back(int'(exp_q[i]));
      slots.push_back(-1);
      b_in_valid = 1'b1; b_in_byte = 8'h41; b_in_rs = 1'b1; b_in_nib = 1'b0; b_out_ready = 1'b1;
      @(negedge ck);
      b_in_byte = 8'h52;
      for (int i = 0; i < slots.size(); i++) begin
         if (slots[i] < 0) begin
            check($sformatf("b2b_idle_valid%0d", i), b_out_valid, 0);
            check($sformatf("b2b_idle_ready%0d", i), b_in_ready, 1);
         end else begin
            check($sformatf("b2b_valid%0d", i), b_out_valid, 1);
            check($sformatf("b2b_data%0d", i), b_out_data, 8'(slots[i]));
         end
         if (i == 5) b_in_valid = 1'b0;
         @(negedge ck);
      end
      check("b2b_final_idle", b_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
